// File: rtl/i_alu_seq_ctrl.sv
// Multi-cycle sequencer for the I-type ALU (addi, addiu, andi, ori, slti).
// Takes one instruction per handshake: read rs, run the ALU, write the result back to rt.
module i_alu_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [31:0]       inst,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [31:0]       alu_inst,
  output logic [DATA_W-1:0] alu_a,
  output logic [15:0]       alu_imm,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         inst_reg;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   res_reg;
  logic [CNT_W-1:0]    cnt;
  logic                illegal_q;
  logic                xfer;
  logic                legal_op;
  logic                retire;

  function automatic logic is_i_type(input logic [5:0] op);
    return (op >= 6'd8) && (op <= 6'd12);
  endfunction

  // A flush in IDLE blocks the handshake outright rather than accepting and dropping.
  assign inst_ready = (state == IDLE) && !flush;
  assign xfer       = inst_valid && inst_ready;
  assign legal_op   = is_i_type(inst[31:26]);

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      IDLE: if (xfer && legal_op) state_nxt = READ;
      READ: state_nxt = CAPT;
      CAPT: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        state_nxt = IDLE;
        retire    = !flush;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush && (state != IDLE)) state_nxt = IDLE;
  end

  // Stage boundary: instruction latch, operand capture, result capture, retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      inst_reg  <= '0;
      op_a      <= '0;
      res_reg   <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= xfer && !legal_op;
      if (state == IDLE && xfer && legal_op) inst_reg <= inst;
      if (state == CAPT) op_a <= rf_rdata;
      if (state == EXEC) res_reg <= alu_result;
      if (retire) cnt <= cnt + 1'b1;
    end
  end

  // r0 is hard-wired: the write is dropped but the instruction still retires.
  assign rf_we       = retire && (inst_reg[20:16] != 5'd0);
  assign done        = retire;
  assign illegal     = illegal_q;
  assign retired_cnt = cnt;
  assign rf_raddr    = REG_AW'(inst_reg[25:21]);
  assign rf_waddr    = REG_AW'(inst_reg[20:16]);
  assign rf_wdata    = res_reg;
  assign alu_inst    = inst_reg;
  assign alu_a       = op_a;
  assign alu_imm     = inst_reg[15:0];

endmodule

// File: tb/tb_i_alu_seq_ctrl.sv
// Directed bench for i_alu_seq_ctrl with a registered-read register file and I-type ALU model.
module tb_i_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] inst = '0;
  logic        flush = 1'b0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata = '0;
  logic [31:0] alu_inst;
  logic [31:0] alu_a;
  logic [15:0] alu_imm;
  logic [31:0] alu_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        done;
  logic        illegal;
  logic [15:0] retired_cnt;

  // Second instance with a narrow counter for the wrap check.
  logic        w_rst_n = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [31:0] w_inst = {6'd11, 5'd0, 5'd0, 16'd0};
  logic [4:0]  w_raddr;
  logic [31:0] w_alu_inst;
  logic [31:0] w_alu_a;
  logic [15:0] w_alu_imm;
  logic        w_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic        w_done;
  logic        w_illegal;
  logic [3:0]  w_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] regs [32] = '{1: 32'd10, 3: 32'h0000_00F0, 4: 32'd3, default: 32'd0};

  logic [7:0]  ready_at;
  int          we_cnt, we_cyc, done_cnt, done_cyc, ill_cnt, ill_cyc;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata;

  always #5 clk = ~clk;

  i_alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .flush(flush), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_inst(alu_inst), .alu_a(alu_a), .alu_imm(alu_imm), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done(done),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  i_alu_seq_ctrl #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .inst_valid(w_valid), .inst_ready(w_ready),
    .inst(w_inst), .flush(1'b0), .rf_raddr(w_raddr), .rf_rdata(32'd0),
    .alu_inst(w_alu_inst), .alu_a(w_alu_a), .alu_imm(w_alu_imm), .alu_result(32'd0),
    .rf_we(w_we), .rf_waddr(w_waddr), .rf_wdata(w_wdata), .done(w_done),
    .illegal(w_illegal), .retired_cnt(w_cnt)
  );

  // Register file: registered read, write on rf_we.
  always @(posedge clk) begin
    rf_rdata <= regs[rf_raddr];
    if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
  end

  // I-type ALU: addi/addiu sign-extend, andi/ori zero-extend, slti signed compare.
  always_comb begin
    alu_result = 32'd0;
    case (alu_inst[31:26])
      6'd8, 6'd9: alu_result = alu_a + {{16{alu_imm[15]}}, alu_imm};
      6'd10:      alu_result = alu_a & {16'd0, alu_imm};
      6'd11:      alu_result = alu_a | {16'd0, alu_imm};
      6'd12:      alu_result = ($signed(alu_a) < $signed({{16{alu_imm[15]}}, alu_imm})) ? 32'd1 : 32'd0;
      default:    alu_result = 32'd0;
    endcase
  end

  // Issues one instruction and records outputs for six cycles after the transfer edge.
  task automatic send(input logic [31:0] w, input int flush_k);
    we_cnt = 0; we_cyc = 0; done_cnt = 0; done_cyc = 0; ill_cnt = 0; ill_cyc = 0;
    ready_at = '0; obs_waddr = '0; obs_wdata = '0;
    @(negedge clk);
    inst = w;
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    inst = 32'hDEAD_BEEF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      flush = (k == flush_k);
      #1;
      ready_at[k] = inst_ready;
      if (rf_we) begin we_cnt++; we_cyc = k; obs_waddr = rf_waddr; obs_wdata = rf_wdata; end
      if (done) begin done_cnt++; done_cyc = k; end
      if (illegal) begin ill_cnt++; ill_cyc = k; end
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (inst_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", inst_ready); end
    n_cmp++; if ({rf_we, done, illegal} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got=%b want=000", {rf_we, done, illegal}); end
    n_cmp++; if (retired_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%h want=0", retired_cnt); end
    n_cmp++; if (alu_inst !== 32'd0 || alu_a !== 32'd0 || alu_imm !== 16'd0) begin n_bad++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_inst, alu_a, alu_imm); end
    n_cmp++; if (rf_raddr !== 5'd0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_rf got=%h/%h/%h want=0", rf_raddr, rf_waddr, rf_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    send({6'd8, 5'd1, 5'd2, 16'd5}, 0);
    n_cmp++; if (we_cnt !== 1 || we_cyc !== 4) begin n_bad++; $display("FAIL addi_we cnt=%0d cyc=%0d want 1 at 4", we_cnt, we_cyc); end
    n_cmp++; if (obs_waddr !== 5'd2 || obs_wdata !== 32'd15) begin n_bad++; $display("FAIL addi_wb got=%0d/%0d want=2/15", obs_waddr, obs_wdata); end
    n_cmp++; if (done_cnt !== 1 || done_cyc !== 4) begin n_bad++; $display("FAIL addi_done cnt=%0d cyc=%0d want 1 at 4", done_cnt, done_cyc); end
    n_cmp++; if (ready_at[4:1] !== 4'b0000 || ready_at[5] !== 1'b1) begin n_bad++; $display("FAIL addi_ready got=%b want=x1_0000x", ready_at); end
    n_cmp++; if (retired_cnt !== 16'd1) begin n_bad++; $display("FAIL addi_cnt got=%0d want=1", retired_cnt); end
    n_cmp++; if (alu_imm !== 16'd5) begin n_bad++; $display("FAIL addi_imm got=%h want=5", alu_imm); end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [4] = '{6'd0, 6'd7, 6'd13, 6'd63};
    for (int i = 0; i < 4; i++) begin
      send({ops[i], 5'd1, 5'd2, 16'd1}, 0);
      n_cmp++; if (ill_cnt !== 1 || ill_cyc !== 1) begin n_bad++; $display("FAIL illegal_pulse op=%0d cnt=%0d cyc=%0d want 1 at 1", ops[i], ill_cnt, ill_cyc); end
      n_cmp++; if (we_cnt !== 0 || done_cnt !== 0 || ready_at[6:1] !== 6'h3F) begin n_bad++; $display("FAIL illegal_quiet op=%0d we=%0d done=%0d ready=%b want 0/0/111111", ops[i], we_cnt, done_cnt, ready_at[6:1]); end
    end
    n_cmp++; if (alu_inst !== {6'd8, 5'd1, 5'd2, 16'd5} || retired_cnt !== 16'd1) begin n_bad++; $display("FAIL illegal_nolatch got=%h cnt=%0d want=%h cnt=1", alu_inst, retired_cnt, {6'd8, 5'd1, 5'd2, 16'd5}); end
  endtask

  task automatic test_rt_zero();
    send({6'd11, 5'd3, 5'd0, 16'h000F}, 0);
    n_cmp++; if (done_cnt !== 1 || done_cyc !== 4 || we_cnt !== 0) begin n_bad++; $display("FAIL rt0 done=%0d@%0d we=%0d want 1@4 we=0", done_cnt, done_cyc, we_cnt); end
    n_cmp++; if (retired_cnt !== 16'd2 || rf_wdata !== 32'h0000_00FF) begin n_bad++; $display("FAIL rt0_cnt got=%0d wdata=%h want=2/000000ff", retired_cnt, rf_wdata); end
  endtask

  task automatic test_flush();
    send({6'd10, 5'd1, 5'd5, 16'hFFFF}, 3);
    n_cmp++; if (we_cnt !== 0 || done_cnt !== 0) begin n_bad++; $display("FAIL flush_exec we=%0d done=%0d want 0/0", we_cnt, done_cnt); end
    n_cmp++; if (ready_at[4] !== 1'b1 || retired_cnt !== 16'd2) begin n_bad++; $display("FAIL flush_exec_ready got=%b cnt=%0d want 1/2", ready_at[4], retired_cnt); end
    send({6'd12, 5'd4, 5'd6, 16'd7}, 0);
    n_cmp++; if (we_cnt !== 1 || we_cyc !== 4 || obs_waddr !== 5'd6 || obs_wdata !== 32'd1) begin n_bad++; $display("FAIL slti got we=%0d@%0d addr=%0d data=%0d want 1@4 6/1", we_cnt, we_cyc, obs_waddr, obs_wdata); end
    n_cmp++; if (retired_cnt !== 16'd3) begin n_bad++; $display("FAIL slti_cnt got=%0d want=3", retired_cnt); end
    send({6'd8, 5'd1, 5'd10, 16'd1}, 4);
    n_cmp++; if (we_cnt !== 0 || done_cnt !== 0 || ready_at[5] !== 1'b1) begin n_bad++; $display("FAIL flush_wb we=%0d done=%0d ready=%b want 0/0/1", we_cnt, done_cnt, ready_at[5]); end
    n_cmp++; if (retired_cnt !== 16'd3) begin n_bad++; $display("FAIL flush_wb_cnt got=%0d want=3", retired_cnt); end
  endtask

  task automatic test_flush_idle();
    int seen = 0;
    @(negedge clk);
    inst = {6'd8, 5'd1, 5'd11, 16'd2};
    inst_valid = 1'b1;
    flush = 1'b1;
    #1;
    n_cmp++; if (inst_ready !== 1'b0) begin n_bad++; $display("FAIL flush_idle_ready got=%b want=0", inst_ready); end
    @(negedge clk);
    inst_valid = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (done || rf_we || !inst_ready) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_idle_ignored got=%0d busy cycles want=0", seen); end
  endtask

  task automatic test_back_to_back();
    int d1 = 0, d2 = 0;
    logic [31:0] w1 = '0, w2 = '0;
    logic [4:0]  a1 = '0, a2 = '0;
    logic        r5 = 1'b0;
    @(negedge clk);
    inst = {6'd9, 5'd1, 5'd9, 16'h8000};
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst = {6'd8, 5'd2, 5'd8, 16'hFFFF};
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      #1;
      if (k == 5) r5 = inst_ready;
      if (done && d1 == 0) begin d1 = k; w1 = rf_wdata; a1 = rf_waddr; end
      else if (done) begin d2 = k; w2 = rf_wdata; a2 = rf_waddr; end
      if (k == 6) inst_valid = 1'b0;
    end
    n_cmp++; if (d1 !== 4 || a1 !== 5'd9 || w1 !== 32'hFFFF_800A) begin n_bad++; $display("FAIL b2b_first at=%0d addr=%0d data=%h want 4/9/ffff800a", d1, a1, w1); end
    n_cmp++; if (d2 !== 9 || a2 !== 5'd8 || w2 !== 32'd14) begin n_bad++; $display("FAIL b2b_second at=%0d addr=%0d data=%h want 9/8/0000000e", d2, a2, w2); end
    n_cmp++; if (r5 !== 1'b1 || retired_cnt !== 16'd5) begin n_bad++; $display("FAIL b2b_ready r5=%b cnt=%0d want 1/5", r5, retired_cnt); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    inst = {6'd8, 5'd1, 5'd7, 16'd1};
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (inst_ready !== 1'b1 || {rf_we, done, illegal} !== 3'b000) begin n_bad++; $display("FAIL rstmid_ctrl ready=%b pulses=%b want 1/000", inst_ready, {rf_we, done, illegal}); end
    n_cmp++; if (retired_cnt !== 16'd0 || alu_inst !== 32'd0 || alu_a !== 32'd0 || rf_raddr !== 5'd0 || rf_wdata !== 32'd0) begin n_bad++; $display("FAIL rstmid_regs cnt=%0d inst=%h a=%h raddr=%0d wdata=%h want 0", retired_cnt, alu_inst, alu_a, rf_raddr, rf_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (rf_we || done) seen++;
    end
    n_cmp++; if (seen !== 0 || regs[7] !== 32'd0) begin n_bad++; $display("FAIL rstmid_nowrite pulses=%0d r7=%0d want 0/0", seen, regs[7]); end
  endtask

  task automatic test_wrap();
    int n = 0;
    logic [3:0] c15 = 4'hA, c16 = 4'hA;
    @(negedge clk);
    w_rst_n = 1'b1;
    w_valid = 1'b1;
    for (int k = 0; k < 200 && n < 16; k++) begin
      @(negedge clk);
      #1;
      if (w_done) begin
        n++;
        @(negedge clk);
        #1;
        if (n == 15) c15 = w_cnt;
        if (n == 16) c16 = w_cnt;
      end
    end
    w_valid = 1'b0;
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL wrap_timeout done_pulses=%0d want=16", n); end
    n_cmp++; if (c15 !== 4'hF || c16 !== 4'h0) begin n_bad++; $display("FAIL wrap_cnt got=%h->%h want=f->0", c15, c16); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_illegal();
    test_rt_zero();
    test_flush();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
